// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core pipeline: stage-register state,
// exception side-band layout and the occupancy decode.
package beta_pkg;

   localparam int PIPE_PAYLOAD_W = 128;
   localparam int PIPE_DATA_W    = 32;
   localparam int PIPE_CAUSE_W   = 4;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_FULL  = 2'd1,
      PIPE_SKID  = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic                    exc;
      logic [PIPE_CAUSE_W-1:0] cause;
      logic [PIPE_DATA_W-1:0]  val;
   } pipe_exc_t;

   localparam logic [PIPE_CAUSE_W-1:0] PIPE_CAUSE_ILLEGAL = 4'd2;

   function automatic logic [1:0] pipe_occupancy(input pipe_state_t state);
      case (state)
         PIPE_FULL: return 2'd1;
         PIPE_SKID: return 2'd2;
         default:   return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/beta_pipe_slot.sv
// One pipeline entry register with load enable and synchronous clear.
// Clear wins over load so a flush can never be overridden by a same-cycle load.
module beta_pipe_slot #(
   parameter int Width = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [Width-1:0] i_data,
   output logic [Width-1:0] o_data
);

   logic [Width-1:0] r_data;

   // NOTE: the data register is reset as well as the valid bits, so the stage
   // outputs are all-zero out of reset rather than X; this costs one reset net.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of process order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_data <= '0;
      end else if (i_clear) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/beta_elastic_pipe.sv
// Elastic pipeline register between beta core stages: valid/ready handshake,
// optional two-entry skid buffer, PCU stall/flush, occupancy and new-entry pulse.
module beta_elastic_pipe
   import beta_pkg::*;
#(
   parameter int PayloadWidth = PIPE_PAYLOAD_W,
   parameter int DataWidth    = PIPE_DATA_W,
   parameter int CauseWidth   = PIPE_CAUSE_W,
   parameter bit SkidEn       = 1'b1,
   parameter bit ClearOnFlush = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    pip_valid_i,
   output logic                    pip_ready_o,
   input  logic [PayloadWidth-1:0] pip_payload_i,
   input  logic                    pip_exc_i,
   input  logic [CauseWidth-1:0]   pip_exc_cause_i,
   input  logic [DataWidth-1:0]    pip_exc_val_i,
   output logic                    pip_valid_o,
   input  logic                    pip_ready_i,
   output logic [PayloadWidth-1:0] pip_payload_o,
   output logic                    pip_exc_o,
   output logic [CauseWidth-1:0]   pip_exc_cause_o,
   output logic [DataWidth-1:0]    pip_exc_val_o,
   output logic                    pip_new_instr_o,
   output logic [1:0]              pip_occupancy_o,
   input  logic                    pip_stall_i,
   input  logic                    pip_flush_i
);

   localparam int EntryWidth = PayloadWidth + 1 + CauseWidth + DataWidth;

   pipe_state_t           r_state, w_state_nxt;
   logic                  r_new_instr, w_new_instr_nxt;
   logic                  w_valid, w_rdy_eff, w_ready, w_in_fire, w_out_fire;
   logic                  w_main_load, w_skid_load, w_clear;
   logic [EntryWidth-1:0] w_in_entry, w_main_d, w_main_q, w_skid_q;

   assign w_valid    = (r_state != PIPE_EMPTY);
   assign w_rdy_eff  = pip_ready_i & ~pip_stall_i;
   assign w_out_fire = w_valid & w_rdy_eff;
   // With the skid buffer, ready depends on registered state only.
   assign w_ready    = SkidEn ? (r_state != PIPE_SKID) : (~w_valid | w_rdy_eff);
   assign w_in_fire  = pip_valid_i & w_ready;
   assign w_clear    = pip_flush_i & ClearOnFlush;

   assign w_in_entry = {pip_payload_i, pip_exc_i, pip_exc_cause_i, pip_exc_val_i};
   assign w_main_d   = (r_state == PIPE_SKID) ? w_skid_q : w_in_entry;

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_new_instr_nxt = 1'b0;
      w_main_load     = 1'b0;
      w_skid_load     = 1'b0;
      case (r_state)
         PIPE_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt     = PIPE_FULL;
               w_main_load     = 1'b1;
               w_new_instr_nxt = 1'b1;
            end
         end
         PIPE_FULL: begin
            if (w_in_fire && w_out_fire) begin
               w_main_load     = 1'b1;
               w_new_instr_nxt = 1'b1;
            end else if (w_in_fire && SkidEn) begin
               w_state_nxt = PIPE_SKID;
               w_skid_load = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt = PIPE_EMPTY;
            end
         end
         PIPE_SKID: begin
            if (w_out_fire) begin
               w_state_nxt     = PIPE_FULL;
               w_main_load     = 1'b1;
               w_new_instr_nxt = 1'b1;
            end
         end
         default: w_state_nxt = PIPE_EMPTY;
      endcase
      if (pip_flush_i) begin
         w_state_nxt     = PIPE_EMPTY;
         w_new_instr_nxt = 1'b0;
         w_main_load     = 1'b0;
         w_skid_load     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= PIPE_EMPTY;
         r_new_instr <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_new_instr <= w_new_instr_nxt;
      end
   end

   beta_pipe_slot #(.Width(EntryWidth)) u_main (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .i_load (w_main_load),
      .i_clear(w_clear),
      .i_data (w_main_d),
      .o_data (w_main_q)
   );

   if (SkidEn) begin : g_skid
      beta_pipe_slot #(.Width(EntryWidth)) u_skid (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .i_load (w_skid_load),
         .i_clear(w_clear),
         .i_data (w_in_entry),
         .o_data (w_skid_q)
      );
   end else begin : g_no_skid
      assign w_skid_q = '0;
   end

   assign pip_ready_o     = w_ready;
   assign pip_valid_o     = w_valid;
   assign pip_new_instr_o = r_new_instr;
   assign pip_occupancy_o = pipe_occupancy(r_state);
   assign {pip_payload_o, pip_exc_o, pip_exc_cause_o, pip_exc_val_o} = w_main_q;

endmodule

// File: doc/beta_elastic_pipe.md
Name: beta_elastic_pipe

Overview:
- Generic, parametrised pipeline register for the beta core.
- Successor to the fixed-field stage registers. It carries an opaque payload plus exception side-band between any two stages.
- Adds a valid/ready handshake, an optional skid buffer (registered, non-combinational ready), an external stall, flush, occupancy reporting, and a one-shot "new entry" pulse.
- Placed between fetch/decode/execute/memory stages; the Pipeline Control Unit drives stall and flush.

Parameters:
- PayloadWidth, 128, width of the opaque stage payload (control word, operands, pc, ...).
- DataWidth, 32, width of the exception value (tval) field.
- CauseWidth, 4, width of the exception cause field.
- SkidEn, 1, 1 = two-entry skid buffer with registered pip_ready_o; 0 = single register with pass-through ready.
- ClearOnFlush, 1, 1 = payload/exception registers zeroed on flush; 0 = only valid bits cleared.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- pip_valid_i  in  1  upstream entry valid
- pip_ready_o  out  1  block can accept an entry this cycle
- pip_payload_i  in  PayloadWidth  upstream payload
- pip_exc_i  in  1  entry carries an exception (e.g. illegal instruction)
- pip_exc_cause_i  in  CauseWidth  exception cause
- pip_exc_val_i  in  DataWidth  exception value (instruction word / address)
- pip_valid_o  out  1  output entry valid
- pip_ready_i  in  1  downstream accepts
- pip_payload_o  out  PayloadWidth  output payload
- pip_exc_o  out  1  output exception flag
- pip_exc_cause_o  out  CauseWidth  output cause
- pip_exc_val_o  out  DataWidth  output exception value
- pip_new_instr_o  out  1  one-cycle pulse, first cycle an entry is presented
- pip_occupancy_o  out  2  entries held (0..2)
- pip_stall_i  in  1  PCU hold: blocks output transfer
- pip_flush_i  in  1  PCU flush: discard all entries

Behaviour:
- Reset (async, rstn_i=0):
  - all valid bits 0, all payload/exception registers 0.
  - Outputs: pip_valid_o=0, pip_new_instr_o=0, pip_occupancy_o=0, pip_exc_o=0, data outputs 0.
  - pip_ready_o=1, visible from the first cycle after deassertion.
- Entry = {payload, exc, cause, val}, moved atomically.
- Handshake:
  - in_fire = pip_valid_i & pip_ready_o.
  - Effective downstream ready: rdy_eff = pip_ready_i & ~pip_stall_i.
  - out_fire = pip_valid_o & rdy_eff.
  - Latency 1 cycle: an entry accepted at edge N is presented after N when empty.
- SkidEn=1:
  - FSM states and transitions:
    - EMPTY: in_fire -> FULL.
    - FULL:
      - in_fire & ~out_fire -> SKID; the new entry goes to the skid register.
      - in_fire & out_fire -> FULL; main register reloads.
      - ~in_fire & out_fire -> EMPTY.
    - SKID: out_fire -> FULL; skid moves to main. No input is accepted in this state.
  - pip_ready_o = (state != SKID), driven from registered state only; no combinational path from pip_ready_i.
  - Order preserved; an entry is never dropped or duplicated except by flush.
- SkidEn=0:
  - Single register; pip_ready_o = ~valid | rdy_eff (combinational).
  - States limited to EMPTY/FULL; occupancy max 1.
- Stall: freezes the output entry and state; input is still accepted into free slots (EMPTY->FULL, FULL->SKID).
- Flush (synchronous, highest priority after reset):
  - Next state EMPTY, occupancy 0; any same-cycle in_fire is discarded.
  - Payload registers are zeroed iff ClearOnFlush=1.
  - Flush overrides stall. Flush during reset has no extra effect.
- pip_new_instr_o:
  - High in the first cycle an entry occupies the output, both after EMPTY->FULL and after an out_fire that presents the next entry.
  - Low while the same entry is held by stall or back-pressure. Low after flush.
  - Registered pulse; back-to-back entries give a pulse every cycle.
- pip_exc_* travel with the payload; no special behaviour otherwise.
- pip_occupancy_o: EMPTY=0, FULL=1, SKID=2; registered.

Decomposition:
- beta_pkg gains:
  - pipe_state_t enum {PIPE_EMPTY, PIPE_FULL, PIPE_SKID}.
  - pipe_exc_t struct {exc, cause, val} using CauseWidth/DataWidth defaults.
  - Constant PIPE_CAUSE_ILLEGAL.
- One natural sub-module: beta_pipe_slot. It is a single entry register with load enable and clear; it is instantiated as main and skid.

Test Plan:
- Reset then stream payload 0x1,0x2,0x3 with pip_ready_i=1 -> outputs appear 1 cycle later in order, one pip_new_instr_o pulse per entry, pip_occupancy_o=1.
- Accept 0xA, hold pip_ready_i=0, offer 0xB -> 0xB enters skid, occupancy=2, pip_ready_o=0. Release ready -> 0xA then 0xB out on consecutive cycles, then ready_o=1.
- pip_stall_i=1 for 3 cycles with 0xC presented and pip_ready_i=1 -> 0xC held, pip_new_instr_o high only in its first cycle, no out_fire until stall drops.
- In SKID state assert pip_flush_i with pip_valid_i=1 payload 0xD -> next cycle valid_o=0, occupancy=0, payload_o=0 (ClearOnFlush=1), 0xD never appears.
- Entry with exc_i=1, cause=2, val=0xDEADBEEF -> emerges with identical exception fields alongside its payload.
- Assert rstn_i low asynchronously mid-cycle while FULL -> outputs zero immediately without waiting for a clock edge. After release, ready_o=1 and normal transfers resume.
